mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that sits directly downstream of the single-cycle core's data-memory write bus (MemWrite/DataAdr/WriteData). Stores addressed to its TXDATA word are queued in a small FIFO and serialised as 8N1 frames on a tx pin. It also exposes a read-only status word so firmware can poll FIFO and transmitter state. It sits beside data memory in top; the top-level address decode gives it priority on its two words.

Parameters:
BASE_ADDR, 32'h0000_0200, word address of TXDATA; STATUS is at BASE_ADDR+4
CLKS_PER_BIT, 16, clk cycles per serial bit (minimum 2)
FIFO_DEPTH, 8, byte entries (power of two, minimum 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  core store strobe
DataAdr  input  32  core data address
WriteData  input  32  core store data
ReadData  output  32  status word, combinational; 0 when not selected
Sel  output  1  combinational; 1 when DataAdr equals BASE_ADDR or BASE_ADDR+4
tx  output  1  serial line, registered, idle high
busy  output  1  1 while a frame is in progress (FSM not IDLE)

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, FSM to IDLE, tx=1, busy=0, overflow=0, bit and baud counters=0. A frame in progress is aborted immediately.
- Decode: exact 32-bit match only; misaligned or other addresses do not select and have no effect.
- Push: MemWrite=1 and DataAdr==BASE_ADDR at a rising edge pushes WriteData[7:0]; WriteData[31:8] is ignored.
- Full: a push while full is dropped and sets the sticky overflow flag.
- Simultaneous pop and push while full: the push is accepted and count is unchanged.
- Overflow clear: MemWrite=1 to BASE_ADDR+4 with WriteData[3]=1 clears overflow. Other STATUS bits are read-only. A clear and an overflowing push in the same cycle leave overflow=1.
- STATUS read value: bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[7:4]=count, rest 0. Count is saturated to 4 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Latency: push at edge N with FSM IDLE and FIFO empty → pop at edge N+1; tx falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. The bit counter counts 0..7.

Decomposition:
- Shared header mmio_defs.vh holds:
  - TXDATA_OFF=0 and STATUS_OFF=4
  - STATUS bit positions
  - FSM state encodings (2-bit localparams)
- Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push, pop, dout, full, empty, count.
  - Same clk and active-low asynchronous reset.
  - Read-during-write when empty is not required: a pop is only issued when the FIFO is non-empty.
- mmio_uart_tx contains the decode, status and overflow logic, and the TX FSM.

Test Plan:
- CLKS_PER_BIT=4. Deassert reset, store 0x00000041 to 0x200 → tx sequence per 4 cycles: 0,1,0,0,0,0,0,1,0,1. busy=1 for exactly 40 cycles, then 0.
- Three back-to-back stores 0x55, 0xAA, 0x0F → three contiguous frames, 120 cycles with no idle-high gap between stop and next start. STATUS reads empty=1 afterwards.
- Fill the FIFO while the first frame runs: 10 stores with FIFO_DEPTH=8 → exactly 9 bytes transmitted (1 in flight + 8 queued), STATUS bit3=1. Store 0x8 to 0x204 → bit3=0.
- Store to 0x201, 0x1FC and 0x208 → Sel=0, no frame, count stays 0.
- Assert reset for 1 cycle mid-DATA of a 0x41 frame with 2 bytes queued → tx=1 immediately, busy=0, STATUS=0x00000002 (empty only), no further frames.
- Read STATUS with 3 bytes queued and the FSM active → ReadData=0x00000034.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, TX FSM states and the count saturation helper.
package mmio_uart_tx_pkg;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  function automatic logic [3:0] sat_count4(input int unsigned cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory write bus as seen by the UART: store strobe, address and
// data from the core; status read data and select back to the top-level mux.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Sel;

  modport master (output MemWrite, DataAdr, WriteData, input ReadData, Sel);
  modport slave  (input MemWrite, DataAdr, WriteData, output ReadData, Sel);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle; pops while empty are ignored.
module mmio_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores are queued in a FIFO and
// serialised on tx; STATUS exposes FIFO, busy and sticky overflow state.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0200,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state, w_state_d;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift, w_shift_d;
  logic          r_tx, w_tx_d;
  logic          r_overflow;

  logic          w_sel_tx, w_sel_st, w_push, w_clr_ovf, w_pop, w_bit_end;
  logic          w_full, w_empty;
  logic [7:0]    w_dout;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          w_unused_wdata;

  // Address decode and STATUS read-back
  assign w_sel_tx       = (bus.DataAdr == BASE_ADDR + TXDATA_OFF);
  assign w_sel_st       = (bus.DataAdr == BASE_ADDR + STATUS_OFF);
  assign bus.Sel        = w_sel_tx || w_sel_st;
  assign w_push         = bus.MemWrite && w_sel_tx;
  assign w_clr_ovf      = bus.MemWrite && w_sel_st && bus.WriteData[STAT_OVF];
  assign w_unused_wdata = ^bus.WriteData[31:8];

  always_comb begin
    w_status                      = '0;
    w_status[STAT_FULL]           = w_full;
    w_status[STAT_EMPTY]          = w_empty;
    w_status[STAT_BUSY]           = busy;
    w_status[STAT_OVF]            = r_overflow;
    w_status[STAT_CNT_LSB +: 4]   = sat_count4(32'(w_count));
  end

  assign bus.ReadData = w_sel_st ? w_status : '0;

  mmio_uart_tx_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (bus.WriteData[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_bit_end = (r_baud == BAUD_LAST);

  // TX FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // TX FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (!w_empty) w_state_d = StStart;
      StStart: if (w_bit_end) w_state_d = StData;
      StData:  if (w_bit_end && (r_bit == 3'd7)) w_state_d = StStop;
      StStop:  if (w_bit_end) w_state_d = w_empty ? StIdle : StStart;
    endcase
  end

  // TX FSM: outputs; STOP pops on its last cycle so frames run back to back
  always_comb begin
    w_pop = 1'b0;
    unique case (r_state)
      StIdle:  w_pop = !w_empty;
      StStop:  w_pop = w_bit_end && !w_empty;
      default: w_pop = 1'b0;
    endcase
    busy = (r_state != StIdle);
  end

  // tx is registered from the next-state view so it lines up with r_state.
  always_comb begin
    w_shift_d = r_shift;
    if (w_pop) begin
      w_shift_d = w_dout;
    end else if ((r_state == StData) && w_bit_end) begin
      w_shift_d = {1'b0, r_shift[7:1]};
    end
    w_tx_d = 1'b1;
    unique case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;
      if ((r_state == StIdle) || w_bit_end) r_baud <= '0;
      else                                  r_baud <= r_baud + 1'b1;
      if (r_state != StData) r_bit <= '0;
      else if (w_bit_end)    r_bit <= r_bit + 1'b1;
      // A drop sets overflow even if a clear arrives in the same cycle.
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (w_clr_ovf)             r_overflow <= 1'b0;
    end
  end

  assign tx = r_tx;

endmodule
